alu_sequencer: RTL and testbench

Sequential front end for the team's 4-bit, 16-function combinational ALU. It accepts operation commands over a valid/ready interface, drives the ALU operand and select inputs and holds them for a programmable settle time. It then captures the ALU result and carry, and returns them over a valid/ready response interface. An internal accumulator allows chained operations, where the previous result is used as operand A.

---
 rtl/alu_sequencer.sv | 155 +++++++++++++++
 tb/tb_alu_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: sequential front end for a 4-bit, 16-function combinational ALU.
// Takes one command at a time over a valid/ready interface. Drives registered
// operands and a registered select into the ALU and holds them for SETTLE cycles.
// It then captures the ALU result and carry and returns them over a valid/ready
// response interface. An accumulator keeps the last result, so a chained command
// can use it as operand A.
//
// Ports:
//   clk, rst_n              clock; synchronous active-low reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_sel, cmd_a, cmd_b   function select and operands
//   cmd_chain               1 = operand A comes from the accumulator
//   alu_a, alu_b, alu_sel   registered ALU inputs
//   alu_y, alu_cout         ALU result and carry/borrow out
//   rsp_valid/rsp_ready     response handshake
//   rsp_y, rsp_cout         captured result and carry
//   rsp_zero                captured result is zero
//   rsp_seq                 sequence number of this response (wraps at 256)
module alu_sequencer #(
  parameter int WIDTH  = 4,
  parameter int SELW   = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [SELW-1:0]  cmd_sel,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_chain,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SELW-1:0]  alu_sel,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_cout,
  output logic             rsp_zero,
  output logic [7:0]       rsp_seq
);

  typedef enum logic [1:0] {IDLE, HOLD, RESP} state_t;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [7:0]       seq_q, seq_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [SELW-1:0]  alu_sel_q, alu_sel_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic [7:0]       rsp_seq_q, rsp_seq_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      seq_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_zero_q  <= 1'b0;
      rsp_seq_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      seq_q       <= seq_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_y_q     <= rsp_y_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_seq_q   <= rsp_seq_d;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    seq_d       = seq_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_y_d     = rsp_y_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_seq_d   = rsp_seq_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          alu_a_d   = cmd_chain ? acc_q : cmd_a;
          alu_b_d   = cmd_b;
          alu_sel_d = cmd_sel;
          cnt_d     = SETTLE_C;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        cnt_d = cnt_q - 4'd1;
        // Last settle cycle: the ALU output has been stable long enough.
        if (cnt_q == 4'd1) begin
          rsp_y_d     = alu_y;
          rsp_cout_d  = alu_cout;
          rsp_zero_d  = (alu_y == '0);
          rsp_seq_d   = seq_q;
          acc_d       = alu_y;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          seq_d       = seq_q + 8'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs. cmd_ready depends only on the state, and it is forced low while
  // reset is held.
  always_comb begin
    cmd_ready = rst_n && (state_q == IDLE);
    alu_a     = alu_a_q;
    alu_b     = alu_b_q;
    alu_sel   = alu_sel_q;
    rsp_valid = rsp_valid_q;
    rsp_y     = rsp_y_q;
    rsp_cout  = rsp_cout_q;
    rsp_zero  = rsp_zero_q;
    rsp_seq   = rsp_seq_q;
  end

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_chain;
  logic [3:0] cmd_sel, cmd_a, cmd_b;
  logic [3:0] alu_a, alu_b, alu_sel, alu_y;
  logic       alu_cout;
  logic       rsp_valid, rsp_ready, rsp_cout, rsp_zero;
  logic [3:0] rsp_y;
  logic [7:0] rsp_seq;

  logic       cmd_valid3, cmd_ready3, cmd_chain3;
  logic [3:0] cmd_sel3, cmd_a3, cmd_b3;
  logic [3:0] alu_a3, alu_b3, alu_sel3, alu_y3;
  logic       alu_cout3;
  logic       rsp_valid3, rsp_ready3, rsp_cout3, rsp_zero3;
  logic [3:0] rsp_y3;
  logic [7:0] rsp_seq3;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_seq = 8'd0;

  always #5 clk = ~clk;

  // XOR stub ALUs
  assign alu_y     = alu_a ^ alu_b;
  assign alu_cout  = alu_a[3] & alu_b[3];
  assign alu_y3    = alu_a3 ^ alu_b3;
  assign alu_cout3 = alu_a3[3] & alu_b3[3];

  alu_sequencer #(.WIDTH(4), .SELW(4), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_y(alu_y), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
    .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .rsp_seq(rsp_seq)
  );

  alu_sequencer #(.WIDTH(4), .SELW(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_sel(cmd_sel3),
    .cmd_a(cmd_a3), .cmd_b(cmd_b3), .cmd_chain(cmd_chain3),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_sel(alu_sel3),
    .alu_y(alu_y3), .alu_cout(alu_cout3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_y(rsp_y3),
    .rsp_cout(rsp_cout3), .rsp_zero(rsp_zero3), .rsp_seq(rsp_seq3)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sel;
    logic       chain;
    logic [3:0] exp_a;
    logic [3:0] exp_y;
    logic       exp_cout;
    logic       exp_zero;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    exp_seq = 8'd0;
  endtask

  // Full transaction on the SETTLE=1 instance with rsp_ready held high.
  task automatic run_cmd(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel,
                         input logic chain, input logic [3:0] exp_a, input logic [3:0] exp_y,
                         input logic exp_cout, input logic exp_zero, input string tag);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin step(); n++; end
    if (!cmd_ready) chk({tag, "_ready_timeout"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_chain = chain;
    step();
    cmd_valid = 1'b0;
    chk({tag, "_alu_a"}, 32'(alu_a), 32'(exp_a));
    chk({tag, "_alu_b"}, 32'(alu_b), 32'(b));
    chk({tag, "_alu_sel"}, 32'(alu_sel), 32'(sel));
    n = 0;
    while (!rsp_valid && n < 20) begin step(); n++; end
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_rsp_y"}, 32'(rsp_y), 32'(exp_y));
    chk({tag, "_rsp_cout"}, 32'(rsp_cout), 32'(exp_cout));
    chk({tag, "_rsp_zero"}, 32'(rsp_zero), 32'(exp_zero));
    chk({tag, "_rsp_seq"}, 32'(rsp_seq), 32'(exp_seq));
    exp_seq = exp_seq + 8'd1;
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{a:4'hC, b:4'h3, sel:4'h6, chain:1'b0, exp_a:4'hC, exp_y:4'hF, exp_cout:1'b0, exp_zero:1'b0};
    vecs[1] = '{a:4'h7, b:4'hF, sel:4'h6, chain:1'b1, exp_a:4'hF, exp_y:4'h0, exp_cout:1'b1, exp_zero:1'b1};
    vecs[2] = '{a:4'h7, b:4'h7, sel:4'h1, chain:1'b0, exp_a:4'h7, exp_y:4'h0, exp_cout:1'b0, exp_zero:1'b1};
    vecs[3] = '{a:4'h8, b:4'h8, sel:4'h2, chain:1'b0, exp_a:4'h8, exp_y:4'h0, exp_cout:1'b1, exp_zero:1'b1};
    vecs[4] = '{a:4'h9, b:4'h5, sel:4'hE, chain:1'b1, exp_a:4'h0, exp_y:4'h5, exp_cout:1'b0, exp_zero:1'b0};
    vecs[5] = '{a:4'h1, b:4'hA, sel:4'hF, chain:1'b1, exp_a:4'h5, exp_y:4'hF, exp_cout:1'b0, exp_zero:1'b0};

    cmd_valid = 1'b0; cmd_a = 4'h0; cmd_b = 4'h0; cmd_sel = 4'h0; cmd_chain = 1'b0;
    rsp_ready = 1'b1;
    cmd_valid3 = 1'b0; cmd_a3 = 4'h0; cmd_b3 = 4'h0; cmd_sel3 = 4'h0; cmd_chain3 = 1'b0;
    rsp_ready3 = 1'b1;

    // Reset: all outputs zero, cmd_ready low while held, high after release
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_y", 32'(rsp_y), 32'd0);
    chk("rst_rsp_cout", 32'(rsp_cout), 32'd0);
    chk("rst_rsp_zero", 32'(rsp_zero), 32'd0);
    chk("rst_rsp_seq", 32'(rsp_seq), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rel_cmd_ready3", 32'(cmd_ready3), 32'd1);
    step();

    // Exact timing, SETTLE=1: accept at edge k, response visible after k+1 for one cycle
    cmd_valid = 1'b1; cmd_a = 4'hA; cmd_b = 4'h5; cmd_sel = 4'h3; cmd_chain = 1'b0;
    step();
    cmd_valid = 1'b0;
    chk("t1_k_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("t1_k_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t1_k_alu_a", 32'(alu_a), 32'hA);
    chk("t1_k_alu_b", 32'(alu_b), 32'h5);
    chk("t1_k_alu_sel", 32'(alu_sel), 32'h3);
    step();
    chk("t1_k1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_k1_rsp_y", 32'(rsp_y), 32'hF);
    chk("t1_k1_rsp_cout", 32'(rsp_cout), 32'd0);
    chk("t1_k1_rsp_zero", 32'(rsp_zero), 32'd0);
    chk("t1_k1_rsp_seq", 32'(rsp_seq), 32'd0);
    chk("t1_k1_cmd_ready", 32'(cmd_ready), 32'd0);
    step();
    chk("t1_k2_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t1_k2_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t1_k2_alu_a_held", 32'(alu_a), 32'hA);

    // Table of vectors (chain sequence and boundaries), starting from a fresh reset
    do_reset();
    for (int i = 0; i < 6; i++)
      run_cmd(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].chain, vecs[i].exp_a,
              vecs[i].exp_y, vecs[i].exp_cout, vecs[i].exp_zero, $sformatf("vec%0d", i));

    // Back-pressure: response held 5 cycles, next command waits
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_a = 4'h9; cmd_b = 4'h8; cmd_sel = 4'h4; cmd_chain = 1'b0;
    step();
    cmd_a = 4'h1; cmd_b = 4'h2; cmd_sel = 4'h5;
    step();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("bp%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp%0d_rsp_y", i), 32'(rsp_y), 32'h1);
      chk($sformatf("bp%0d_rsp_cout", i), 32'(rsp_cout), 32'd1);
      chk($sformatf("bp%0d_rsp_seq", i), 32'(rsp_seq), 32'(exp_seq));
      chk($sformatf("bp%0d_cmd_ready", i), 32'(cmd_ready), 32'd0);
      chk($sformatf("bp%0d_alu_a", i), 32'(alu_a), 32'h9);
      if (i < 5) step();
    end
    rsp_ready = 1'b1;
    exp_seq = exp_seq + 8'd1;
    step();
    chk("bp_rel_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("bp_rel_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("bp_rel_alu_a", 32'(alu_a), 32'h9);
    step();
    cmd_valid = 1'b0;
    chk("bp_acc_alu_a", 32'(alu_a), 32'h1);
    chk("bp_acc_alu_b", 32'(alu_b), 32'h2);
    chk("bp_acc_cmd_ready", 32'(cmd_ready), 32'd0);
    step();
    chk("bp_next_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("bp_next_rsp_y", 32'(rsp_y), 32'h3);
    chk("bp_next_rsp_seq", 32'(rsp_seq), 32'(exp_seq));
    exp_seq = exp_seq + 8'd1;
    step();

    // SETTLE=3 instance: capture at k+3, ALU inputs stable k..k+3
    cmd_valid3 = 1'b1; cmd_a3 = 4'h6; cmd_b3 = 4'hB; cmd_sel3 = 4'h7; cmd_chain3 = 1'b0;
    step();
    cmd_valid3 = 1'b0; cmd_a3 = 4'h0; cmd_b3 = 4'h0; cmd_sel3 = 4'h0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("s3_k%0d_rsp_valid", i), 32'(rsp_valid3), 32'd0);
      chk($sformatf("s3_k%0d_alu_a", i), 32'(alu_a3), 32'h6);
      chk($sformatf("s3_k%0d_alu_b", i), 32'(alu_b3), 32'hB);
      chk($sformatf("s3_k%0d_alu_sel", i), 32'(alu_sel3), 32'h7);
      chk($sformatf("s3_k%0d_cmd_ready", i), 32'(cmd_ready3), 32'd0);
      step();
    end
    chk("s3_k3_rsp_valid", 32'(rsp_valid3), 32'd1);
    chk("s3_k3_rsp_y", 32'(rsp_y3), 32'hD);
    chk("s3_k3_rsp_cout", 32'(rsp_cout3), 32'd0);
    chk("s3_k3_alu_a", 32'(alu_a3), 32'h6);
    step();
    chk("s3_k4_rsp_valid", 32'(rsp_valid3), 32'd0);
    chk("s3_k4_cmd_ready", 32'(cmd_ready3), 32'd1);

    // 257 commands from reset: sequence number wraps 255 -> 0
    do_reset();
    for (int i = 0; i < 257; i++) begin
      logic [7:0] iv;
      logic [3:0] a, b;
      iv = 8'(i);
      a = iv[3:0];
      b = iv[7:4] ^ 4'h5;
      if (i == 255) chk("wrap_exp_seq_255", 32'(exp_seq), 32'd255);
      run_cmd(a, b, 4'h2, 1'b0, a, a ^ b, a[3] & b[3], (a ^ b) == 4'h0, $sformatf("seq%0d", i));
    end

    // Reset while in HOLD: response dropped, accumulator cleared
    run_cmd(4'h3, 4'h5, 4'h1, 1'b0, 4'h3, 4'h6, 1'b0, 1'b0, "pre_hold");
    cmd_valid = 1'b1; cmd_a = 4'h9; cmd_b = 4'h1; cmd_sel = 4'h1; cmd_chain = 1'b0;
    step();
    cmd_valid = 1'b0;
    chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_seq = 8'd0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("hold_rst%0d_rsp_valid", i), 32'(rsp_valid), 32'd0);
      step();
    end
    run_cmd(4'hF, 4'h6, 4'h0, 1'b1, 4'h0, 4'h6, 1'b0, 1'b0, "post_rst_chain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
